// File: rtl/load_sequencer.sv
// Tile-load front end: accepts a word stream and emits registered buffer writes for the bias, weight and IFM phases in that order.
// Define LOAD_SEQ_BIAS_EN to include the BIAS phase; when it is undefined, bias_len is ignored and loading runs WGT then IFM.
module load_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 10,
  parameter logic [1:0] SEL_IFM    = 2'b01,
  parameter logic [1:0] SEL_WGT    = 2'b10,
  parameter logic [1:0] SEL_BIAS   = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   bias_len,
  input  logic [ADDR_WIDTH:0]   wgt_len,
  input  logic [ADDR_WIDTH:0]   ifm_len,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [1:0]            sel,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int            LW  = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] ONE = LW'(1);

`ifdef LOAD_SEQ_BIAS_EN
  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_WGT, S_IFM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WGT, S_IFM, S_DONE} state_t;
`endif

  state_t                  state_reg;
  state_t                  first_state;
  state_t                  after_state;
  logic [LW-1:0]           count_reg;
  logic [LW-1:0]           wgt_len_reg;
  logic [LW-1:0]           ifm_len_reg;
  logic [LW-1:0]           phase_len;
  logic [1:0]              phase_sel;
  logic [1:0]              sel_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    wr_en_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    done_reg;
  logic                    accept;
  logic                    last_beat;

`ifdef LOAD_SEQ_BIAS_EN
  logic [LW-1:0]           bias_len_reg;
`else
  logic                    unused_bias;
  assign unused_bias = ^bias_len;
`endif

  always_comb begin
    phase_len   = '0;
    phase_sel   = 2'b00;
    after_state = S_DONE;
    s_ready     = 1'b0;
    case (state_reg)
`ifdef LOAD_SEQ_BIAS_EN
      S_BIAS: begin
        phase_len   = bias_len_reg;
        phase_sel   = SEL_BIAS;
        s_ready     = 1'b1;
        after_state = (wgt_len_reg != '0) ? S_WGT :
                      (ifm_len_reg != '0) ? S_IFM : S_DONE;
      end
`endif
      S_WGT: begin
        phase_len   = wgt_len_reg;
        phase_sel   = SEL_WGT;
        s_ready     = 1'b1;
        after_state = (ifm_len_reg != '0) ? S_IFM : S_DONE;
      end
      S_IFM: begin
        phase_len   = ifm_len_reg;
        phase_sel   = SEL_IFM;
        s_ready     = 1'b1;
        after_state = S_DONE;
      end
      default: begin
        phase_len   = '0;
      end
    endcase
  end

  // Zero-length phases are skipped right at start, so a phase is only ever entered with length >= 1.
  always_comb begin
`ifdef LOAD_SEQ_BIAS_EN
    first_state = (bias_len != '0) ? S_BIAS :
                  (wgt_len  != '0) ? S_WGT  :
                  (ifm_len  != '0) ? S_IFM  : S_DONE;
`else
    first_state = (wgt_len  != '0) ? S_WGT  :
                  (ifm_len  != '0) ? S_IFM  : S_DONE;
`endif
  end

  assign accept    = s_valid && s_ready;
  assign last_beat = (count_reg + ONE) == phase_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      wgt_len_reg  <= '0;
      ifm_len_reg  <= '0;
`ifdef LOAD_SEQ_BIAS_EN
      bias_len_reg <= '0;
`endif
      sel_reg      <= 2'b00;
      data_reg     <= '0;
      wr_en_reg    <= 1'b0;
      addr_reg     <= '0;
      done_reg     <= 1'b0;
    end else begin
      wr_en_reg <= accept;
      sel_reg   <= accept ? phase_sel : 2'b00;
      data_reg  <= accept ? s_data : '0;
      addr_reg  <= accept ? count_reg[ADDR_WIDTH-1:0] : '0;
      done_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            wgt_len_reg  <= wgt_len;
            ifm_len_reg  <= ifm_len;
`ifdef LOAD_SEQ_BIAS_EN
            bias_len_reg <= bias_len;
`endif
            count_reg    <= '0;
            state_reg    <= first_state;
            done_reg     <= (first_state == S_DONE);
          end
        end
        S_DONE: state_reg <= S_IDLE;
        default: begin
          if (accept) begin
            if (last_beat) begin
              count_reg <= '0;
              state_reg <= after_state;
              done_reg  <= (after_state == S_DONE);
            end else begin
              count_reg <= count_reg + ONE;
            end
          end
        end
      endcase
    end
  end

  assign sel      = sel_reg;
  assign data_out = data_reg;
  assign wr_en    = wr_en_reg;
  assign wr_addr  = addr_reg;
  assign busy     = (state_reg != S_IDLE);
  assign done     = done_reg;

endmodule

// File: tb/tb_load_sequencer.sv
// Randomised and directed bench for load_sequencer against a queue-of-expected-writes model.
// Honours LOAD_SEQ_BIAS_EN the same way the design does.
module tb_load_sequencer;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   bias_len;
  logic [AW:0]   wgt_len;
  logic [AW:0]   ifm_len;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [1:0]    sel;
  logic [DW-1:0] data_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;

  load_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .bias_len(bias_len), .wgt_len(wgt_len), .ifm_len(ifm_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .sel(sel), .data_out(data_out), .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
  } slot_t;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;

  slot_t slots[$];
  int    m_mode = M_IDLE;
  int    n_checks = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  int    seen_sel10 = 0;
  int    seen_sel11 = 0;
  int    seen_writes = 0;
  int    last_addr = 0;
  int    write_cycle = 0;
  int    cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Expected write list for one tile: each entry is one beat's buffer select and address.
  task automatic build_slots(input logic [AW:0] bl, input logic [AW:0] wl, input logic [AW:0] il);
    slots.delete();
`ifdef LOAD_SEQ_BIAS_EN
    for (int i = 0; i < int'(bl); i++) slots.push_back({2'b11, AW'(i)});
`else
    if (bl == '1) slots.delete();
`endif
    for (int i = 0; i < int'(wl); i++) slots.push_back({2'b10, AW'(i)});
    for (int i = 0; i < int'(il); i++) slots.push_back({2'b01, AW'(i)});
  endtask

  task automatic step(input logic r, input logic st, input logic v, input logic [DW-1:0] d,
                      input logic [AW:0] bl, input logic [AW:0] wl, input logic [AW:0] il);
    logic          e_wr;
    logic [1:0]    e_sel;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_addr;
    logic          e_done;
    slot_t         item;
    rst = r; start = st; s_valid = v; s_data = d;
    bias_len = bl; wgt_len = wl; ifm_len = il;
    #1;
    check("s_ready", 64'(s_ready), 64'(m_mode == M_LOAD));
    e_wr = 1'b0; e_sel = 2'b00; e_data = '0; e_addr = '0; e_done = 1'b0;
    if (r) begin
      m_mode = M_IDLE;
      slots.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (st) begin
          build_slots(bl, wl, il);
          if (slots.size() == 0) begin
            m_mode = M_DONE;
            e_done = 1'b1;
          end else begin
            m_mode = M_LOAD;
          end
        end
        M_LOAD: if (v) begin
          item   = slots.pop_front();
          e_wr   = 1'b1;
          e_sel  = item.sel;
          e_addr = item.addr;
          e_data = d;
          if (slots.size() == 0) begin
            m_mode = M_DONE;
            e_done = 1'b1;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
    check("wr_en", 64'(wr_en), 64'(e_wr));
    check("sel", 64'(sel), 64'(e_sel));
    check("data_out", 64'(data_out), 64'(e_data));
    check("wr_addr", 64'(wr_addr), 64'(e_addr));
    check("done", 64'(done), 64'(e_done));
    check("busy", 64'(busy), 64'(m_mode != M_IDLE));
    if (wr_en === 1'b1) begin
      seen_writes++;
      last_addr   = int'(wr_addr);
      write_cycle = cyc;
      if (sel == 2'b10) seen_sel10++;
      if (sel == 2'b11) seen_sel11++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic clear_stats();
    seen_sel10 = 0; seen_sel11 = 0; seen_writes = 0; last_addr = 0;
  endtask

  initial begin
    logic [AW:0] rl0, rl1, rl2;
    int done_cyc;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    bias_len = '0; wgt_len = '0; ifm_len = '0;
    @(posedge clk); @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 32'hdead, 11'd3, 11'd3, 11'd3);

    // Nominal 2/3/4 tile with continuous valid
    clear_stats();
    step(1'b0, 1'b1, 1'b0, '0, 11'd2, 11'd3, 11'd4);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, DW'(i), 11'h7ff, 11'h7ff, 11'h7ff);
    idle(3);
`ifdef LOAD_SEQ_BIAS_EN
    check("nominal_writes", 64'(seen_writes), 64'd9);
`else
    check("nominal_writes", 64'(seen_writes), 64'd7);
    check("no_bias_sel", 64'(seen_sel11), 64'd0);
`endif

    // All-zero lengths
    clear_stats();
    step(1'b0, 1'b1, 1'b1, 32'h55, 11'd0, 11'd0, 11'd0);
    step(1'b0, 1'b0, 1'b1, 32'h66, 11'd0, 11'd0, 11'd0);
    idle(2);
    check("zero_writes", 64'(seen_writes), 64'd0);

    // Skipped weight phase
    clear_stats();
    step(1'b0, 1'b1, 1'b0, '0, 11'd1, 11'd0, 11'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, DW'(32'h100 + i), '0, '0, '0);
    idle(2);
    check("skip_wgt_no_sel10", 64'(seen_sel10), 64'd0);

    // Gapped valid during IFM
    clear_stats();
    step(1'b0, 1'b1, 1'b0, '0, 11'd0, 11'd0, 11'd4);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, (i % 2) == 0, DW'(32'h200 + i), '0, '0, '0);
    idle(2);
    check("gap_writes", 64'(seen_writes), 64'd4);
    check("gap_last_addr", 64'(last_addr), 64'd3);

    // Reset mid-weight phase drops the in-flight beat, next tile restarts at address 0
    clear_stats();
    step(1'b0, 1'b1, 1'b0, '0, 11'd0, 11'd5, 11'd0);
    step(1'b0, 1'b0, 1'b1, 32'hA0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 32'hA1, '0, '0, '0);
    step(1'b1, 1'b0, 1'b1, 32'hA2, '0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, 11'd0, 11'd3, 11'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, DW'(32'hB0 + i), '0, '0, '0);
    idle(2);
    check("rst_writes", 64'(seen_writes), 64'd5);

    // Full-depth IFM phase with start pulses while busy
    clear_stats();
    done_cyc = 0;
    step(1'b0, 1'b1, 1'b0, '0, 11'd0, 11'd0, 11'd1024);
    for (int i = 0; i < 1024; i++) begin
      step(1'b0, (i % 100) == 7, 1'b1, $urandom, 11'd1, 11'd1, 11'd1);
      if (done === 1'b1) done_cyc = cyc;
    end
    idle(3);
    check("full_writes", 64'(seen_writes), 64'd1024);
    check("full_last_addr", 64'(last_addr), 64'd1023);
    check("full_done_with_last", 64'(done_cyc), 64'(write_cycle));

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rl0 = AW'($urandom_range(0, 4));
      rl1 = AW'($urandom_range(0, 4));
      rl2 = AW'($urandom_range(0, 5));
      step(($urandom_range(0, 249) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), $urandom, rl0, rl1, rl2);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
